// File: rtl/rca_seq_ctrl.sv
// rtl/rca_seq_ctrl.sv - nibble-serial wide add/subtract sequencer around one shared 4-bit ripple-carry adder
//
// full_adder    : single-bit full adder cell.
// rca_using_fa  : 4-bit ripple-carry adder built from full_adder cells.
//   a, b        : 4-bit addends
//   cin         : carry into bit 0
//   sum         : 4-bit sum
//   cout        : carry out of bit 3
//
// rca_seq_ctrl  : processes one nibble per clock, least-significant first,
//                 through a single rca_using_fa instance.
//   NIBBLES      : number of 4-bit slices per operand (2..16), W = 4*NIBBLES
//   clk_in       : rising-edge clock
//   rst_n_in     : synchronous active-low reset
//   start_in     : request, accepted when start_in=1 and ready_out=1
//   a_in, b_in   : W-bit operands, sampled only at accept
//   c_in         : carry-in (add) / borrow-in (sub), sampled only at accept
//   sub_in       : 0 = A+B+c_in, 1 = A-B-c_in, sampled only at accept
//   ready_out    : high only while idle
//   done_out     : one-cycle pulse when the result registers update
//   sum_out      : W-bit result, held until the next done_out
//   carry_out    : carry out of the MSB nibble (sub: 1 = no borrow)
//   overflow_out : signed two's-complement overflow of the W-bit operation

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module rca_using_fa (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    // chain[i] is the carry into bit i; chain[4] leaves the adder.
    logic [4:0] chain;

    assign chain[0] = cin;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_bit
            full_adder u_fa (
                .a    (a[i]),
                .b    (b[i]),
                .cin  (chain[i]),
                .sum  (sum[i]),
                .cout (chain[i+1])
            );
        end
    endgenerate

    assign cout = chain[4];

endmodule

module rca_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 start_in,
    input  logic [4*NIBBLES-1:0] a_in,
    input  logic [4*NIBBLES-1:0] b_in,
    input  logic                 c_in,
    input  logic                 sub_in,
    output logic                 ready_out,
    output logic                 done_out,
    output logic [4*NIBBLES-1:0] sum_out,
    output logic                 carry_out,
    output logic                 overflow_out
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [W-1:0]    a_reg;
    // B operand already conditioned for subtraction (one's complement when sub).
    logic [W-1:0]    b_reg;
    logic            carry_reg;
    logic [W-1:0]    work;

    logic [3:0]      nib_a;
    logic [3:0]      nib_b;
    logic [3:0]      nib_sum;
    logic            nib_cout;
    logic [W-1:0]    work_next;

    assign ready_out = (state == IDLE);

    assign nib_a = a_reg[4*idx +: 4];
    assign nib_b = b_reg[4*idx +: 4];

    rca_using_fa u_rca (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_reg),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // Work value with the current nibble merged in; on the final nibble this
    // is the complete result, so sum_out can load it on the same edge.
    always_comb begin
        work_next = work;
        work_next[4*idx +: 4] = nib_sum;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state        <= IDLE;
            idx          <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            carry_reg    <= 1'b0;
            work         <= '0;
            sum_out      <= '0;
            carry_out    <= 1'b0;
            overflow_out <= 1'b0;
            done_out     <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        a_reg     <= a_in;
                        // A - B - c == A + ~B + ~c in two's complement.
                        b_reg     <= sub_in ? ~b_in : b_in;
                        carry_reg <= sub_in ? ~c_in : c_in;
                        idx       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    work      <= work_next;
                    carry_reg <= nib_cout;
                    if (idx == LAST) begin
                        sum_out      <= work_next;
                        carry_out    <= nib_cout;
                        // Overflow: operands agree in sign but the result does not.
                        overflow_out <= (a_reg[W-1] == b_reg[W-1]) &&
                                        (nib_sum[3] != a_reg[W-1]);
                        done_out     <= 1'b1;
                        idx          <= '0;
                        state        <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb/tb_rca_seq_ctrl.sv - self-checking bench for rca_seq_ctrl (NIBBLES=4)

module tb_rca_seq_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk_in;
    logic         rst_n_in;
    logic         start_in;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         c_in;
    logic         sub_in;
    logic         ready_out;
    logic         done_out;
    logic [W-1:0] sum_out;
    logic         carry_out;
    logic         overflow_out;

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   accepts[$];
    int   checks = 0;
    int   errors = 0;

    rca_seq_ctrl #(.NIBBLES(NIB)) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .start_in     (start_in),
        .a_in         (a_in),
        .b_in         (b_in),
        .c_in         (c_in),
        .sub_in       (sub_in),
        .ready_out    (ready_out),
        .done_out     (done_out),
        .sum_out      (sum_out),
        .carry_out    (carry_out),
        .overflow_out (overflow_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full-width reference: plain W+1-bit arithmetic, independent of nibbles.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic sub);
        exp_t         e;
        logic [W-1:0] bp;
        logic [W:0]   full;
        bp   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, (sub ? ~c : c)};
        e.sum   = full[W-1:0];
        e.carry = full[W];
        e.ovf   = (a[W-1] == bp[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic pop_compare(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_sum"},   32'(sum_out),      32'(e.sum));
            check({tag, "_carry"}, 32'(carry_out),    32'(e.carry));
            check({tag, "_ovf"},   32'(overflow_out), 32'(e.ovf));
        end
    endtask

    // Directed op with spec-given expected results; checks latency and pulse shape.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic sub,
                         input logic [W-1:0] es, input logic ec, input logic eo);
        exp_t e;
        int   cnt;
        a_in = a; b_in = b; c_in = c; sub_in = sub; start_in = 1'b1;
        check({tag, "_ready_pre"}, 32'(ready_out), 32'd1);
        @(posedge clk_in); #1;
        start_in = 1'b0;
        e.sum = es; e.carry = ec; e.ovf = eo;
        sb.push_back(e);
        check({tag, "_ready_busy"}, 32'(ready_out), 32'd0);
        cnt = 0;
        while (!done_out && cnt < 20) begin
            @(posedge clk_in); #1;
            cnt++;
        end
        check({tag, "_latency"}, 32'(cnt), 32'(NIB));
        if (done_out) pop_compare(tag);
        check({tag, "_ready_done"}, 32'(ready_out), 32'd0);
        @(posedge clk_in); #1;
        check({tag, "_done_width"}, 32'(done_out), 32'd0);
        check({tag, "_ready_back"}, 32'(ready_out), 32'd1);
    endtask

    initial begin
        exp_t e;
        int   ndone;

        rst_n_in = 1'b0; start_in = 1'b0;
        a_in = '0; b_in = '0; c_in = 1'b0; sub_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_ready",    32'(ready_out),    32'd1);
        check("rst_done",     32'(done_out),     32'd0);
        check("rst_sum",      32'(sum_out),      32'd0);
        check("rst_carry",    32'(carry_out),    32'd0);
        check("rst_ovf",      32'(overflow_out), 32'd0);
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;

        do_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
        do_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Abort mid-RUN with a one-edge reset at accept+2.
        a_in = 16'h1234; b_in = 16'h1111; c_in = 1'b1; sub_in = 1'b0; start_in = 1'b1;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        @(posedge clk_in); #1;
        rst_n_in = 1'b0;
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        check("abort_sum",   32'(sum_out),      32'd0);
        check("abort_carry", 32'(carry_out),    32'd0);
        check("abort_ovf",   32'(overflow_out), 32'd0);
        check("abort_ready", 32'(ready_out),    32'd1);
        ndone = 0;
        repeat (8) begin
            @(posedge clk_in); #1;
            if (done_out) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        do_op("post_abort", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        do_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        do_op("add_cin",    16'h00F0, 16'h0010, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0);

        // Reset and start on the same edge: reset wins.
        rst_n_in = 1'b0; start_in = 1'b1; a_in = 16'h0005; b_in = 16'h0003;
        @(posedge clk_in); #1;
        rst_n_in = 1'b1; start_in = 1'b0;
        check("rst_start_ready", 32'(ready_out), 32'd1);
        ndone = 0;
        repeat (6) begin
            @(posedge clk_in); #1;
            if (done_out) ndone++;
        end
        check("rst_start_no_done", 32'(ndone), 32'd0);

        // Continuous start with operands changing every cycle.
        start_in = 1'b1;
        for (int cyc = 0; cyc < 18; cyc++) begin
            a_in   = 16'($urandom);
            b_in   = 16'($urandom);
            c_in   = 1'($urandom);
            sub_in = 1'($urandom);
            if (ready_out) begin
                e = model(a_in, b_in, c_in, sub_in);
                sb.push_back(e);
                accepts.push_back(cyc);
            end
            @(posedge clk_in); #1;
            if (done_out) pop_compare("stream");
        end
        start_in = 1'b0;
        repeat (8) begin
            @(posedge clk_in); #1;
            if (done_out) pop_compare("stream_drain");
        end
        check("stream_accepts", 32'(accepts.size()), 32'd3);
        for (int k = 0; k < accepts.size() && k < 3; k++)
            check("stream_accept_edge", 32'(accepts[k]), 32'(6 * k));
        check("stream_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
